inertial_fusion_integ: RTL and testbench
========================================

// Module: inertial_fusion_integ
// PURPOSE
//  Parametrised pitch integrator with accelerometer fusion and self-calibration.
//  - Learns the gyro pitch-rate offset at start-up by averaging 2^CAL_LOG2 samples.
//  - Integrates the compensated rate and nudges the result toward accel pitch by +/-FUSE_STEP.
//  - Sits between the inertial SPI interface (source of vld/ptch_rt/AZ) and the balance controller.
// PARAMETERS
//  DATA_W     16        width of ptch_rt, AZ, ptch, rt_offset
//  FRAC_W     11        fraction bits of integrator; INT_W = DATA_W+FRAC_W
//  CAL_LOG2   4         log2 of calibration sample count (1..8)
//  RT_OFF_DEF 16'h03C2  rate offset used at reset and when BYPASS_CAL=1
//  AZ_OFFSET  16'hFE80  accel Z offset
//  FUDGE      327       accel-to-pitch gain, unsigned, 12 bit
//  FUDGE_SH   13        right shift applied to AZ product
//  FUSE_STEP  1024      fusion correction per sample, in integrator LSBs
//  BYPASS_CAL 0         1: skip CAL, start in RUN with RT_OFF_DEF
// PORTS
//  clk        in   1        system clock
//  rst        in   1        reset
//  vld        in   1        one-cycle strobe: new ptch_rt/AZ sample
//  ptch_rt    in   DATA_W   raw signed pitch rate
//  AZ         in   DATA_W   raw signed Z acceleration
//  cal_req    in   1        one-cycle request to re-run calibration
//  ptch       out  DATA_W   fused signed pitch = ptch_int[INT_W-1:FRAC_W]
//  ptch_vld   out  1        one-cycle pulse: ptch updated
//  cal_done   out  1        high while in RUN
//  rt_offset  out  DATA_W   current rate offset
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset values: ptch_int=0, ptch=0, ptch_vld=0, cal_count=0, cal_sum=0, rt_offset=RT_OFF_DEF.
//  - Reset state: CAL, with cal_done=0; if BYPASS_CAL=1, RUN with cal_done=1.
//  - rst mid-operation discards any partial calibration and clears the integrator.
//  - CAL state:
//    - On vld: cal_sum += sext(ptch_rt) and cal_count++; cal_sum is signed, DATA_W+CAL_LOG2 bits.
//    - On the vld that is sample 2^CAL_LOG2, the next edge sets:
//      rt_offset = cal_sum_final >>> CAL_LOG2 (arithmetic, floor), cal_count=0, state=RUN.
//    - cal_done rises in the same cycle as the state change.
//    - ptch_int is held at 0 and ptch_vld stays 0 throughout CAL.
//  - RUN state, on vld, evaluated combinationally from current registers:
//    - comp = ptch_rt - rt_offset, computed in DATA_W+1 bits (no wrap).
//    - az_c = AZ - AZ_OFFSET, computed in DATA_W+1 bits.
//    - acc = (az_c*FUDGE)>>>FUDGE_SH, saturated to DATA_W signed.
//    - fuse = (acc > ptch) ? +FUSE_STEP : -FUSE_STEP; the equal case gives -FUSE_STEP.
//    - ptch_int <= sat_INT_W(ptch_int - sext(comp) + fuse), computed in INT_W+2 bits.
//    - Saturation clamps to [-2^(INT_W-1), 2^(INT_W-1)-1]; the integrator never wraps.
//    - ptch_vld=1 in the cycle after the vld edge, i.e. the cycle in which the new ptch is visible.
//  - Latency: vld -> ptch/ptch_vld = 1 clk. Back-to-back vld every cycle is supported.
//  - cal_req, in any state:
//    - Next edge: state=CAL, cal_done=0, cal_sum=0, cal_count=0, ptch_int=0.
//    - rt_offset keeps its old value until the new calibration completes.
//  - cal_req and vld in the same cycle: cal_req wins and that sample is discarded.
//  - cal_req while already in CAL restarts the count.
//  - cal_req is ignored when BYPASS_CAL=1.
// TESTING
//  1 rst=1 for 2 clk -> ptch=0, ptch_vld=0, cal_done=0, rt_offset=16'h03C2.
//  2 16 vld with ptch_rt=16'h0400 x8 then 16'h0401 x8 -> cal_done=1 one clk after 16th vld,
//    rt_offset=16'h0400 (floor), ptch=0 and no ptch_vld throughout.
//  3 RUN, ptch_rt=rt_offset, AZ=16'hFE80 (acc=0), one vld -> ptch_int=-1024, ptch=16'hFFFF.
//    Next vld -> ptch=16'h0000; ptch alternates FFFF/0000 with one ptch_vld per vld.
//  4 RUN, ptch_rt=rt_offset+16'h7FFF, AZ=16'hFE80, vld every clk for 2200 clk
//    -> ptch reaches 16'h8000 and holds (no wrap to positive).
//  5 RUN, cal_req and vld same cycle -> no ptch_vld, ptch=0, cal_done=0 next clk.
//    rt_offset unchanged until 16 further vld complete calibration.
//  6 rst asserted after 7 CAL samples -> cal restarts; 16 fresh samples of 16'hFFFD
//    -> rt_offset=16'hFFFD.

Source files
------------

// File: rtl/inertial_fusion_integ.sv
// Pitch integrator with start-up gyro offset calibration and accel-pitch fusion.
// One sample per vld. ptch/ptch_vld follow one clock after the sample edge.
module inertial_fusion_integ #(
  parameter int                DATA_W     = 16,
  parameter int                FRAC_W     = 11,
  parameter int                CAL_LOG2   = 4,
  parameter logic [DATA_W-1:0] RT_OFF_DEF = 16'h03C2,
  parameter logic [DATA_W-1:0] AZ_OFFSET  = 16'hFE80,
  parameter logic [11:0]       FUDGE      = 12'd327,
  parameter int                FUDGE_SH   = 13,
  parameter int                FUSE_STEP  = 1024,
  parameter bit                BYPASS_CAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [DATA_W-1:0] ptch_rt,
  input  logic [DATA_W-1:0] AZ,
  input  logic              cal_req,
  output logic [DATA_W-1:0] ptch,
  output logic              ptch_vld,
  output logic              cal_done,
  output logic [DATA_W-1:0] rt_offset
);

  localparam int INT_W  = DATA_W + FRAC_W;
  localparam int SUM_W  = DATA_W + CAL_LOG2;
  localparam int PROD_W = DATA_W + 14;
  localparam logic [INT_W+1:0]    FUSE_P   = (INT_W+2)'(FUSE_STEP);
  localparam logic [CAL_LOG2-1:0] CAL_LAST = '1;
  localparam logic [CAL_LOG2-1:0] CAL_ONE  = CAL_LOG2'(1);

  typedef enum logic {CAL, RUN} state_t;

  state_t              state;
  logic [INT_W-1:0]    ptch_int;
  logic [SUM_W-1:0]    cal_sum;
  logic [CAL_LOG2-1:0] cal_count;

  logic [SUM_W-1:0]         cal_sum_nxt;
  logic [DATA_W:0]          comp;
  logic [DATA_W:0]          az_c;
  logic [PROD_W-1:0]        prod;
  logic signed [PROD_W-1:0] shifted;
  logic [PROD_W-DATA_W:0]   acc_hi;
  logic                     acc_ok;
  logic [DATA_W-1:0]        acc;
  logic [INT_W+1:0]         fuse;
  logic [INT_W+1:0]         nxt;
  logic [2:0]               nxt_hi;
  logic                     nxt_ok;
  logic [INT_W-1:0]         nxt_sat;

  assign ptch = ptch_int[INT_W-1:FRAC_W];

  assign cal_sum_nxt = cal_sum + {{CAL_LOG2{ptch_rt[DATA_W-1]}}, ptch_rt};

  // Differences are formed one bit wider so extreme inputs cannot wrap.
  assign comp = {ptch_rt[DATA_W-1], ptch_rt} - {rt_offset[DATA_W-1], rt_offset};
  assign az_c = {AZ[DATA_W-1], AZ} - {AZ_OFFSET[DATA_W-1], AZ_OFFSET};

  // Low PROD_W bits of a sign-extended x zero-extended product are the signed product.
  assign prod    = {{13{az_c[DATA_W]}}, az_c} * {{(DATA_W+2){1'b0}}, FUDGE};
  assign shifted = $signed(prod) >>> FUDGE_SH;
  assign acc_hi  = shifted[PROD_W-1:DATA_W-1];
  assign acc_ok  = (&acc_hi) | ~(|acc_hi);
  assign acc     = acc_ok ? shifted[DATA_W-1:0]
                          : {shifted[PROD_W-1], {(DATA_W-1){~shifted[PROD_W-1]}}};

  assign fuse = ($signed(acc) > $signed(ptch)) ? FUSE_P : -FUSE_P;

  assign nxt = {{2{ptch_int[INT_W-1]}}, ptch_int}
             - {{(INT_W+1-DATA_W){comp[DATA_W]}}, comp}
             + fuse;
  assign nxt_hi  = nxt[INT_W+1:INT_W-1];
  assign nxt_ok  = (&nxt_hi) | ~(|nxt_hi);
  assign nxt_sat = nxt_ok ? nxt[INT_W-1:0]
                          : {nxt[INT_W+1], {(INT_W-1){~nxt[INT_W+1]}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BYPASS_CAL ? RUN : CAL;
      cal_done  <= BYPASS_CAL;
      ptch_int  <= '0;
      ptch_vld  <= 1'b0;
      cal_count <= '0;
      cal_sum   <= '0;
      rt_offset <= RT_OFF_DEF;
    end else begin
      ptch_vld <= 1'b0;
      // A recalibration request drops any same-cycle sample.
      if (cal_req && !BYPASS_CAL) begin
        state     <= CAL;
        cal_done  <= 1'b0;
        cal_sum   <= '0;
        cal_count <= '0;
        ptch_int  <= '0;
      end else if (state == CAL) begin
        ptch_int <= '0;
        if (vld) begin
          if (cal_count == CAL_LAST) begin
            rt_offset <= cal_sum_nxt[SUM_W-1:CAL_LOG2];
            cal_sum   <= '0;
            cal_count <= '0;
            state     <= RUN;
            cal_done  <= 1'b1;
          end else begin
            cal_sum   <= cal_sum_nxt;
            cal_count <= cal_count + CAL_ONE;
          end
        end
      end else if (vld) begin
        ptch_int <= nxt_sat;
        ptch_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inertial_fusion_integ.sv
// Bench for inertial_fusion_integ: constant vector table, directed corner sequences,
// and randomized traffic checked against an integer reference model.
module tb_inertial_fusion_integ;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        cal_req;
  logic [15:0] ptch;
  logic        ptch_vld;
  logic        cal_done;
  logic [15:0] rt_offset;

  inertial_fusion_integ dut (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .cal_req   (cal_req),
    .ptch      (ptch),
    .ptch_vld  (ptch_vld),
    .cal_done  (cal_done),
    .rt_offset (rt_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, plain integers.
  longint m_pint;
  int     m_sum, m_cnt, m_off;
  bit     m_run, m_pvld;

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_clock(input bit r, input bit v, input logic [15:0] rt,
                             input logic [15:0] az, input bit cr);
    int comp, azc, acc, p, fuse;
    longint nx;
    if (r) begin
      m_pint = 0; m_sum = 0; m_cnt = 0; m_off = s16(16'h03C2); m_run = 0; m_pvld = 0;
    end else begin
      m_pvld = 0;
      if (cr) begin
        m_run = 0; m_sum = 0; m_cnt = 0; m_pint = 0;
      end else if (!m_run) begin
        if (v) begin
          m_sum += s16(rt);
          m_cnt++;
          if (m_cnt == 16) begin
            m_off = m_sum >>> 4;
            m_run = 1; m_cnt = 0; m_sum = 0;
          end
        end
      end else if (v) begin
        comp = s16(rt) - m_off;
        azc  = s16(az) - s16(16'hFE80);
        acc  = (azc * 327) >>> 13;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        p    = int'(m_pint >>> 11);
        fuse = (acc > p) ? 1024 : -1024;
        nx   = m_pint - longint'(comp) + longint'(fuse);
        if (nx > 64'sd67108863) nx = 64'sd67108863;
        if (nx < -64'sd67108864) nx = -64'sd67108864;
        m_pint = nx;
        m_pvld = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [15:0] rt,
                       input logic [15:0] az, input bit cr);
    rst = r; vld = v; ptch_rt = rt; AZ = az; cal_req = cr;
    @(posedge clk);
    model_clock(r, v, rt, az, cr);
    #1;
    check("m_ptch",      ptch,               16'(m_pint >>> 11));
    check("m_ptch_vld",  {15'b0, ptch_vld},  {15'b0, m_pvld});
    check("m_cal_done",  {15'b0, cal_done},  {15'b0, m_run});
    check("m_rt_offset", rt_offset,          16'(m_off));
  endtask

  typedef struct {
    bit          v;
    logic [15:0] rt;
    logic [15:0] az;
    bit          cr;
    logic [15:0] e_ptch;
    bit          e_vld;
    bit          e_done;
    logic [15:0] e_off;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] rt, az, big;
    bit v, cr, r;

    rst = 1'b1; vld = 1'b0; ptch_rt = '0; AZ = '0; cal_req = 1'b0;

    // Calibration 8x0400 + 8x0401 floors to 0400; then the alternating zero-rate case,
    // an idle cycle, and a cal_req colliding with vld.
    for (int i = 0; i < 16; i++)
      tbl.push_back('{1'b1, (i < 8) ? 16'h0400 : 16'h0401, 16'h0000, 1'b0,
                      16'h0000, 1'b0, (i == 15), (i == 15) ? 16'h0400 : 16'h03C2});
    tbl.push_back('{1'b1, 16'h0400, 16'hFE80, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0400});
    tbl.push_back('{1'b1, 16'h0400, 16'hFE80, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0400});
    tbl.push_back('{1'b1, 16'h0400, 16'hFE80, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0400});
    tbl.push_back('{1'b0, 16'h0400, 16'hFE80, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'h0400});
    tbl.push_back('{1'b1, 16'h0400, 16'hFE80, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0400});
    tbl.push_back('{1'b1, 16'h0400, 16'hFE80, 1'b0, 16'hFFFF, 1'b1, 1'b1, 16'h0400});
    tbl.push_back('{1'b1, 16'h1234, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0400});

    // Reset held for two clocks.
    cycle(1, 0, 16'h0, 16'h0, 0);
    cycle(1, 0, 16'h0, 16'h0, 0);
    check("rst_ptch",     ptch,               16'h0000);
    check("rst_ptch_vld", {15'b0, ptch_vld},  16'h0000);
    check("rst_cal_done", {15'b0, cal_done},  16'h0000);
    check("rst_rt_off",   rt_offset,          16'h03C2);

    foreach (tbl[i]) begin
      cycle(0, tbl[i].v, tbl[i].rt, tbl[i].az, tbl[i].cr);
      check($sformatf("tbl%0d_ptch", i), ptch, tbl[i].e_ptch);
      check($sformatf("tbl%0d_vld", i),  {15'b0, ptch_vld}, {15'b0, tbl[i].e_vld});
      check($sformatf("tbl%0d_done", i), {15'b0, cal_done}, {15'b0, tbl[i].e_done});
      check($sformatf("tbl%0d_off", i),  rt_offset, tbl[i].e_off);
    end

    // Recalibration after the collision: old offset holds for 15 samples.
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 16'($urandom_range(0, 600)) + 16'h0200, 16'($urandom), 0);
      if (i < 15) begin
        check("recal_hold_off",  rt_offset,         16'h0400);
        check("recal_hold_done", {15'b0, cal_done}, 16'h0000);
      end else begin
        check("recal_done", {15'b0, cal_done}, 16'h0001);
      end
    end

    // Partial calibration interrupted by reset must be discarded.
    cycle(0, 0, 16'h0, 16'h0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 1, 16'h1000 + 16'(i), 16'h0, 0);
    cycle(1, 0, 16'h0, 16'h0, 0);
    check("midrst_off", rt_offset, 16'h03C2);
    for (int i = 0; i < 16; i++) cycle(0, 1, 16'hFFFD, 16'h0, 0);
    check("fffd_off",  rt_offset,         16'hFFFD);
    check("fffd_done", {15'b0, cal_done}, 16'h0001);

    // Large positive compensated rate drives the integrator to negative saturation.
    big = 16'hFFFD + 16'h7FFF;
    for (int i = 0; i < 2200; i++) cycle(0, 1, big, 16'hFE80, 0);
    check("sat_neg_ptch", ptch, 16'h8000);
    cycle(0, 1, big, 16'hFE80, 0);
    check("sat_neg_hold", ptch, 16'h8000);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 999) == 0);
      cr = ($urandom_range(0, 149) == 0);
      v  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) rt = 16'($urandom);
      else rt = 16'($urandom_range(0, 200)) - 16'd100 + 16'(m_off);
      az = ($urandom_range(0, 3) == 0) ? 16'hFE80 : 16'($urandom);
      cycle(r, v, rt, az, cr);
    end

    vld = 1'b0; cal_req = 1'b0; rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
